hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage AArch64 pipeline.
- Drives the en/clr pair of each inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves the following hazards by fixed priority:
  - memory waits
  - multi-cycle EX ops
  - exceptions
  - taken branches
  - load-use hazards
- Tracks redirects that arrive while an instruction fetch is still outstanding.

Parameters:
MC_LAT, 4, cycles a multi-cycle EX op (mul/div) occupies EX, >=2
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_wait  in  1  fetch outstanding (ireq valid, data_ok low)
d_wait  in  1  MEM-stage data access outstanding
ex_mc_start  in  1  multi-cycle op present in EX, not yet started
exc_mem  in  1  exception/eret taken in MEM
br_taken_ex  in  1  taken branch / mispredict resolved in EX
idex_is_load  in  1  instruction in EX is a load
idex_rd  in  REG_W  destination of EX instruction
ifid_rs1, ifid_rs2  in  REG_W  sources of ID instruction
ifid_use1, ifid_use2  in  1  source valid flags
pc_en  out  1  PC update enable
ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr  out  1 each  register controls
mc_busy  out  1  multi-cycle op in progress
squash_pend  out  1  redirect pending against an in-flight fetch

Behaviour:
- Pipeline registers clear only when en=1. While rst_n=0:
  - all *_en=1 and all *_clr=1
  - pc_en=0, mc_busy=0, squash_pend=0
  - state=IDLE, counter=0
- State registers (async reset): mc state {IDLE, MC_BUSY}, mc_cnt width $clog2(MC_LAT+1), squash_pend flag.
- Default outputs: every en=1, every clr=0, pc_en=1.
- Load-use condition: idex_is_load and idex_rd != 31 and ((ifid_use1 and rs1==rd) or (ifid_use2 and rs2==rd)).
- Priority, highest first; outputs are combinational from state and inputs:
  1. Freeze (d_wait or mc_busy or ex_mc_start): pc_en=0, ifid_en=idex_en=exmem_en=0; memwb_en=1, memwb_clr=1 (bubble into WB).
  2. exc_mem: ifid_clr=idex_clr=exmem_clr=1.
  3. br_taken_ex: ifid_clr=idex_clr=1. If i_wait=1 the same cycle, set squash_pend.
  4. Load-use: pc_en=0, ifid_en=0, idex_clr=1.
  5. i_wait: pc_en=0, ifid_clr=1.
- Exception while i_wait=1 also sets squash_pend.
- squash_pend behaviour:
  - While set, ifid_clr=1 every cycle.
  - Cleared on the cycle i_wait falls; that fetch's data is discarded via ifid_clr=1 in that cycle.
  - A new redirect while already pending keeps it set.
- Multi-cycle FSM:
  - IDLE: on ex_mc_start with no d_wait, go MC_BUSY with mc_cnt=MC_LAT-1.
  - MC_BUSY: decrement each cycle; d_wait does not pause the count. At mc_cnt==1 and no d_wait, go IDLE.
  - In the cycle after return to IDLE the op advances (exmem_en=1). ex_mc_start is ignored while busy.
- Simultaneous exc_mem and freeze: freeze wins. exc_mem must be held by MEM until the freeze releases.
- Reset mid-operation: async clear to IDLE. A pending squash is dropped.

Decomposition:
- Shared pipes package: a stage_ctrl_t struct {en, clr} and a pipe_ctrl_t bundle of four stage_ctrl_t plus pc_en, so the top level wires one bundle to the stage registers.
- One natural sub-module, mc_counter: the MC_LAT down-counter and FSM, exposing busy/done.

Test Plan:
- Reset: hold rst_n=0 -> all en=1, all clr=1, pc_en=0. Release -> defaults en=1, clr=0, pc_en=1.
- Load-use: idex_is_load=1, idex_rd=3, ifid_rs1=3, ifid_use1=1 -> one cycle of pc_en=0, ifid_en=0, idex_clr=1. Same with rd=31 -> no stall.
- Multi-cycle (MC_LAT=4): pulse ex_mc_start -> freeze for exactly 4 cycles (mc_busy high 3) -> exmem_en=1 on the 5th.
- Branch during fetch wait: br_taken_ex=1 with i_wait=1 for 3 more cycles -> squash_pend=1. ifid_clr=1 through the cycle i_wait falls. squash_pend=0 the next cycle.
- d_wait plus br_taken_ex same cycle -> freeze only, no clr on IF/ID or ID/EX. After d_wait drops, the branch flush is applied.
- Async reset asserted in MC_BUSY, mc_cnt=2 -> mc_busy=0 immediately. After release, state is IDLE with no residual stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer and its stage registers.
package hazard_ctrl_pkg;

  // Control pair for one inter-stage register; clr only takes effect with en=1.
  typedef struct packed {
    logic en;
    logic clr;
  } stage_ctrl_t;

  // Everything the stage registers and PC need from the sequencer.
  typedef struct packed {
    logic        pc_en;
    stage_ctrl_t ifid;
    stage_ctrl_t idex;
    stage_ctrl_t exmem;
    stage_ctrl_t memwb;
  } pipe_ctrl_t;

  // Multi-cycle EX op tracking.
  typedef enum logic [0:0] {
    StIdle,
    StMcBusy
  } mc_state_e;

  // XZR/SP encoding never creates a data dependency.
  localparam int unsigned ZeroRegIdx = 31;

  localparam stage_ctrl_t StageRun   = '{en: 1'b1, clr: 1'b0};
  localparam stage_ctrl_t StageClear = '{en: 1'b1, clr: 1'b1};

  localparam pipe_ctrl_t PipeDefault = '{
    pc_en: 1'b1, ifid: StageRun, idex: StageRun, exmem: StageRun, memwb: StageRun
  };

  // While in reset every stage register is flushed and the PC is held.
  localparam pipe_ctrl_t PipeReset = '{
    pc_en: 1'b0, ifid: StageClear, idex: StageClear, exmem: StageClear, memwb: StageClear
  };

endpackage

// File: rtl/hazard_ctrl_mc_counter.sv
// Down-counter tracking how long a multi-cycle EX op (mul/div) still occupies EX.
module mc_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic d_wait_i,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned CntW = $clog2(MC_LAT + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(MC_LAT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  mc_state_e       state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  // Next state: load on start, count down regardless of d_wait, and hold at one
  // until the data side is free so the op never leaves EX under a freeze.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !d_wait_i) begin
          state_d = StMcBusy;
          cnt_d   = CntLoad;
        end
      end
      StMcBusy: begin
        if (cnt_q <= CntOne) begin
          if (!d_wait_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            done_o  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == StMcBusy);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives en/clr of every
// inter-stage register and the PC enable from a fixed hazard priority.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned REG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wait,
  input  logic             d_wait,
  input  logic             ex_mc_start,
  input  logic             exc_mem,
  input  logic             br_taken_ex,
  input  logic             idex_is_load,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_use1,
  input  logic             ifid_use2,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exmem_en,
  output logic             exmem_clr,
  output logic             memwb_en,
  output logic             memwb_clr,
  output logic             mc_busy,
  output logic             squash_pend
);

  pipe_ctrl_t ctrl;
  logic       freeze;
  logic       load_use;
  logic       redirect;
  logic       mc_done;
  logic       squash_pend_d, squash_pend_q;

  mc_counter #(
    .MC_LAT(MC_LAT)
  ) u_mc_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (ex_mc_start),
    .d_wait_i(d_wait),
    .busy_o  (mc_busy),
    .done_o  (mc_done)
  );

  // ex_mc_start freezes in its own cycle so the op cannot slip past EX before busy rises.
  assign freeze = d_wait | mc_busy | ex_mc_start;

  assign load_use = idex_is_load && (idex_rd != REG_W'(ZeroRegIdx)) &&
                    ((ifid_use1 && (ifid_rs1 == idex_rd)) ||
                     (ifid_use2 && (ifid_rs2 == idex_rd)));

  // A redirect only counts when it actually takes effect, i.e. not under a freeze.
  assign redirect = !freeze && (exc_mem || br_taken_ex);

  // Hazard resolution by fixed priority; a pending squash flushes IF/ID on top.
  always_comb begin
    ctrl = PipeDefault;
    if (!rst_n) begin
      ctrl = PipeReset;
    end else begin
      if (freeze) begin
        ctrl.pc_en     = 1'b0;
        ctrl.ifid.en   = 1'b0;
        ctrl.idex.en   = 1'b0;
        ctrl.exmem.en  = 1'b0;
        ctrl.memwb.clr = 1'b1;
      end else if (exc_mem) begin
        ctrl.ifid.clr  = 1'b1;
        ctrl.idex.clr  = 1'b1;
        ctrl.exmem.clr = 1'b1;
      end else if (br_taken_ex) begin
        ctrl.ifid.clr = 1'b1;
        ctrl.idex.clr = 1'b1;
      end else if (load_use) begin
        ctrl.pc_en    = 1'b0;
        ctrl.ifid.en  = 1'b0;
        ctrl.idex.clr = 1'b1;
      end else if (i_wait) begin
        ctrl.pc_en    = 1'b0;
        ctrl.ifid.clr = 1'b1;
      end
      // The in-flight fetch belongs to the old path, including the cycle it returns.
      if (squash_pend_q) begin
        ctrl.ifid.clr = 1'b1;
      end
    end
  end

  // Pending while the stale fetch is outstanding; drops the cycle i_wait falls.
  always_comb begin
    squash_pend_d = i_wait && (squash_pend_q || redirect);
  end

  // Squash-pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_pend_q <= 1'b0;
    end else begin
      squash_pend_q <= squash_pend_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid.en;
  assign ifid_clr    = ctrl.ifid.clr;
  assign idex_en     = ctrl.idex.en;
  assign idex_clr    = ctrl.idex.clr;
  assign exmem_en    = ctrl.exmem.en;
  assign exmem_clr   = ctrl.exmem.clr;
  assign memwb_en    = ctrl.memwb.en;
  assign memwb_clr   = ctrl.memwb.clr;
  assign squash_pend = squash_pend_q;

  // Completing the op must release the freeze on the following cycle.
  a_mc_release : assert property (@(posedge clk) disable iff (!rst_n) mc_done |=> !mc_busy);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned MC_LAT = 4;
  localparam int unsigned REG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_wait, d_wait, ex_mc_start, exc_mem, br_taken_ex, idex_is_load;
  logic [REG_W-1:0] idex_rd, ifid_rs1, ifid_rs2;
  logic             ifid_use1, ifid_use2;
  logic             pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
  logic             exmem_en, exmem_clr, memwb_en, memwb_clr, mc_busy, squash_pend;

  // en/clr vectors ordered {ifid, idex, exmem, memwb}.
  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] clr;
    logic       mc_busy;
    logic       squash_pend;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   frz_seen = 0;
  int   busy_seen = 0;

  // Model state: is a long op in EX, how many busy cycles it has spent, and
  // whether the outstanding fetch is known to be on a dead path.
  bit   m_busy;
  int   m_age;
  bit   m_pend;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MC_LAT(MC_LAT),
    .REG_W (REG_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wait      (i_wait),
    .d_wait      (d_wait),
    .ex_mc_start (ex_mc_start),
    .exc_mem     (exc_mem),
    .br_taken_ex (br_taken_ex),
    .idex_is_load(idex_is_load),
    .idex_rd     (idex_rd),
    .ifid_rs1    (ifid_rs1),
    .ifid_rs2    (ifid_rs2),
    .ifid_use1   (ifid_use1),
    .ifid_use2   (ifid_use2),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_clr    (ifid_clr),
    .idex_en     (idex_en),
    .idex_clr    (idex_clr),
    .exmem_en    (exmem_en),
    .exmem_clr   (exmem_clr),
    .memwb_en    (memwb_en),
    .memwb_clr   (memwb_clr),
    .mc_busy     (mc_busy),
    .squash_pend (squash_pend)
  );

  // Expected outputs for the inputs now applied, then advance the model one cycle.
  task automatic model_step();
    exp_t e;
    bit   freeze, lu, redirect;
    if (!rst_n) begin
      e = '{pc_en: 1'b0, en: 4'b1111, clr: 4'b1111, mc_busy: 1'b0, squash_pend: 1'b0};
      m_busy = 0;
      m_age  = 0;
      m_pend = 0;
      exp_q.push_back(e);
      return;
    end
    e = '{pc_en: 1'b1, en: 4'b1111, clr: 4'b0000, mc_busy: m_busy, squash_pend: m_pend};
    freeze = d_wait || m_busy || ex_mc_start;
    lu = idex_is_load && (idex_rd != 5'd31) &&
         ((ifid_use1 && ifid_rs1 == idex_rd) || (ifid_use2 && ifid_rs2 == idex_rd));
    if (freeze) begin
      e.pc_en = 1'b0;
      e.en    = 4'b0001;
      e.clr   = 4'b0001;
    end else if (exc_mem) begin
      e.clr = 4'b1110;
    end else if (br_taken_ex) begin
      e.clr = 4'b1100;
    end else if (lu) begin
      e.pc_en = 1'b0;
      e.en    = 4'b0111;
      e.clr   = 4'b0100;
    end else if (i_wait) begin
      e.pc_en = 1'b0;
      e.clr   = 4'b1000;
    end
    if (m_pend) e.clr[3] = 1'b1;
    exp_q.push_back(e);

    redirect = !freeze && (exc_mem || br_taken_ex);
    m_pend   = i_wait && (m_pend || redirect);
    if (m_busy) begin
      // Op leaves EX once it has spent MC_LAT cycles there and MEM is not stalled.
      if (m_age >= int'(MC_LAT) - 1 && !d_wait) begin
        m_busy = 0;
        m_age  = 0;
      end else begin
        m_age++;
      end
    end else if (ex_mc_start && !d_wait) begin
      m_busy = 1;
      m_age  = 1;
    end
  endtask

  task automatic drive(input logic r, input logic iw, input logic dw, input logic mcs,
                       input logic exc, input logic br, input logic ld,
                       input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                       input logic [REG_W-1:0] rs2, input logic u1, input logic u2);
    @(posedge clk);
    #1;
    rst_n        = r;
    i_wait       = iw;
    d_wait       = dw;
    ex_mc_start  = mcs;
    exc_mem      = exc;
    br_taken_ex  = br;
    idex_is_load = ld;
    idex_rd      = rd;
    ifid_rs1     = rs1;
    ifid_rs2     = rs2;
    ifid_use1    = u1;
    ifid_use2    = u2;
    model_step();
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
  endtask

  function automatic logic [REG_W-1:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd3;
      1:       return 5'd31;
      2:       return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // Monitor: every cycle the DUT presents a fresh control word; compare it.
  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{pc_en: pc_en, en: {ifid_en, idex_en, exmem_en, memwb_en},
            clr: {ifid_clr, idex_clr, exmem_clr, memwb_clr},
            mc_busy: mc_busy, squash_pend: squash_pend};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ctrl_word t=%0t actual pc=%b en=%b clr=%b busy=%b sq=%b required pc=%b en=%b clr=%b busy=%b sq=%b",
                 $time, a.pc_en, a.en, a.clr, a.mc_busy, a.squash_pend,
                 e.pc_en, e.en, e.clr, e.mc_busy, e.squash_pend);
      end
      if (!exmem_en) frz_seen++;
      if (mc_busy) busy_seen++;
    end
  end

  initial begin
    logic r, iw, dw, mcs, exc, br, ld, u1, u2;
    rst_n = 1'b0;
    {i_wait, d_wait, ex_mc_start, exc_mem, br_taken_ex, idex_is_load} = '0;
    {idex_rd, ifid_rs1, ifid_rs2, ifid_use1, ifid_use2} = '0;

    // Reset hold, then release to defaults.
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) idle();

    // Load-use on rs1 stalls; the zero register never does.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd7, 1'b1, 1'b0);
    idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 5'd31, 5'd7, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b1);
    idle();

    // Multi-cycle op: four frozen cycles, three with mc_busy.
    frz_seen  = 0;
    busy_seen = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    repeat (5) idle();
    @(negedge clk);
    #1;
    total += 2;
    if (frz_seen != MC_LAT) begin
      bad++;
      $display("FAIL mc_freeze_len actual=%0d required=%0d", frz_seen, MC_LAT);
    end
    if (busy_seen != MC_LAT - 1) begin
      bad++;
      $display("FAIL mc_busy_len actual=%0d required=%0d", busy_seen, MC_LAT - 1);
    end

    // Branch while a fetch is outstanding, fetch returns three cycles later.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    repeat (3) idle();

    // Exception during fetch wait also arms the squash.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    repeat (2) idle();

    // d_wait masks the branch; the flush lands once d_wait drops.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    idle();

    // Async reset while busy with two cycles left.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    repeat (3) idle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) != 0);
      iw  = ($urandom_range(0, 9) < 3);
      dw  = ($urandom_range(0, 9) < 2);
      mcs = ($urandom_range(0, 11) == 0);
      exc = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 9) < 2);
      ld  = ($urandom_range(0, 9) < 4);
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      drive(r, iw, dw, mcs, exc, br, ld, pick_reg(), pick_reg(), pick_reg(), u1, u2);
    end
    idle();

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
